// File: rtl/usb_packet_decoder_pkg.sv
// rtl/usb_packet_decoder_pkg.sv - shared USB PID encodings, decoder states, CRC5 helpers
package usb_packet_decoder_pkg;

  typedef enum logic [3:0] {
    PID_RESERVED = 4'b0000,
    PID_OUT      = 4'b0001,
    PID_ACK      = 4'b0010,
    PID_DATA0    = 4'b0011,
    PID_PING     = 4'b0100,
    PID_SOF      = 4'b0101,
    PID_NYET     = 4'b0110,
    PID_DATA2    = 4'b0111,
    PID_SPLIT    = 4'b1000,
    PID_IN       = 4'b1001,
    PID_NAK      = 4'b1010,
    PID_DATA1    = 4'b1011,
    PID_PRE      = 4'b1100,
    PID_SETUP    = 4'b1101,
    PID_STALL    = 4'b1110,
    PID_MDATA    = 4'b1111
  } pid_t;

  typedef logic [3:0] rx_state_t;

  localparam rx_state_t ST_SYNC_WAIT = 4'd0;
  localparam rx_state_t ST_IDLE      = 4'd1;
  localparam rx_state_t ST_PID       = 4'd2;
  localparam rx_state_t ST_TOK1      = 4'd3;
  localparam rx_state_t ST_TOK2      = 4'd4;
  localparam rx_state_t ST_TOK_END   = 4'd5;
  localparam rx_state_t ST_HSK       = 4'd6;
  localparam rx_state_t ST_DATA      = 4'd7;
  localparam rx_state_t ST_DISCARD   = 4'd8;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  // PID class lives in the two low PID bits; 2'b00 is the special/unsupported class
  function automatic logic is_token(input logic [1:0] cls);
    return cls == 2'b01;
  endfunction

  function automatic logic is_handshake(input logic [1:0] cls);
    return cls == 2'b10;
  endfunction

  function automatic logic is_data(input logic [1:0] cls);
    return cls == 2'b11;
  endfunction

  function automatic logic pid_check_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  // Eight serial shifts, LSB of the byte first, as the bits arrive on the wire
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_packet_decoder_if.sv
// rtl/usb_packet_decoder_if.sv - byte stream from the bit-level receiver into the decoder
interface usb_packet_decoder_if;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;

  modport master (output rx_active, rx_valid, rx_data, rx_error);
  modport slave  (input  rx_active, rx_valid, rx_data, rx_error);
endinterface

// File: rtl/usb_crc5.sv
// rtl/usb_crc5.sv - byte-wide CRC5 accumulator with residual compare for token packets
module usb_crc5
  import usb_packet_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       step,
  input  logic [7:0] data,
  output logic [4:0] crc,
  output logic       residual_ok
);

  always_ff @(posedge clk) begin
    if (reset || init) crc <= CRC5_INIT;
    else if (step)     crc <= crc5_byte(crc, data);
  end

  assign residual_ok = (crc == CRC5_RESIDUAL);

endmodule

// File: rtl/usb_packet_decoder.sv
// rtl/usb_packet_decoder.sv - classifies received USB packets by PID, checks tokens,
// reports handshakes and forwards data payload bytes
module usb_packet_decoder
  import usb_packet_decoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  usb_packet_decoder_if.slave    rx,
  output logic                   token_valid,
  output logic [3:0]             token_pid,
  output logic [6:0]             token_addr,
  output logic [3:0]             token_endp,
  output logic                   hsk_valid,
  output logic [3:0]             hsk_pid,
  output logic                   data_start,
  output logic [3:0]             data_pid,
  output logic                   data_valid,
  output logic [7:0]             data_byte,
  output logic                   data_end,
  output logic                   pid_error,
  output logic                   crc_error,
  output logic                   pkt_error
);

  rx_state_t  state;
  logic [3:0] pid_q;
  logic [7:0] tok_b1;
  logic [2:0] tok_endp_hi;
  logic       in_pkt;
  logic       crc_step;
  logic       crc_ok;
  logic [4:0] crc_val;

  assign in_pkt   = state inside {ST_PID, ST_TOK1, ST_TOK2, ST_TOK_END, ST_HSK, ST_DATA};
  assign crc_step = (state == ST_TOK1 || state == ST_TOK2) && rx.rx_active && rx.rx_valid;

  usb_crc5 u_crc5 (
    .clk         (clk),
    .reset       (reset),
    .init        (state == ST_PID),
    .step        (crc_step),
    .data        (rx.rx_data),
    .crc         (crc_val),
    .residual_ok (crc_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_SYNC_WAIT;
      pid_q       <= PID_RESERVED;
      tok_b1      <= 8'h00;
      tok_endp_hi <= 3'b000;
      token_valid <= 1'b0;
      token_pid   <= PID_RESERVED;
      token_addr  <= 7'h00;
      token_endp  <= 4'h0;
      hsk_valid   <= 1'b0;
      hsk_pid     <= PID_RESERVED;
      data_start  <= 1'b0;
      data_pid    <= PID_RESERVED;
      data_valid  <= 1'b0;
      data_byte   <= 8'h00;
      data_end    <= 1'b0;
      pid_error   <= 1'b0;
      crc_error   <= 1'b0;
      pkt_error   <= 1'b0;
    end else begin
      token_valid <= 1'b0;
      hsk_valid   <= 1'b0;
      data_start  <= 1'b0;
      data_valid  <= 1'b0;
      data_end    <= 1'b0;
      pid_error   <= 1'b0;
      crc_error   <= 1'b0;
      pkt_error   <= 1'b0;

      // A line error wins over whatever the packet state would otherwise do
      if (in_pkt && rx.rx_error) begin
        pkt_error <= 1'b1;
        state     <= ST_DISCARD;
      end else begin
        case (state)
          ST_SYNC_WAIT: if (!rx.rx_active) state <= ST_IDLE;
          ST_IDLE:      if (rx.rx_active)  state <= ST_PID;
          ST_PID: begin
            if (!rx.rx_active) begin
              pkt_error <= 1'b1;
              state     <= ST_IDLE;
            end else if (rx.rx_valid) begin
              pid_q <= rx.rx_data[3:0];
              if (!pid_check_ok(rx.rx_data)) begin
                pid_error <= 1'b1;
                state     <= ST_DISCARD;
              end else if (is_token(rx.rx_data[1:0])) begin
                state <= ST_TOK1;
              end else if (is_handshake(rx.rx_data[1:0])) begin
                state <= ST_HSK;
              end else if (is_data(rx.rx_data[1:0])) begin
                data_start <= 1'b1;
                data_pid   <= rx.rx_data[3:0];
                state      <= ST_DATA;
              end else begin
                pid_error <= 1'b1;
                state     <= ST_DISCARD;
              end
            end
          end
          ST_TOK1, ST_TOK2: begin
            if (!rx.rx_active) begin
              pkt_error <= 1'b1;
              state     <= ST_IDLE;
            end else if (rx.rx_valid) begin
              if (state == ST_TOK1) begin
                tok_b1 <= rx.rx_data;
                state  <= ST_TOK2;
              end else begin
                tok_endp_hi <= rx.rx_data[2:0];
                state       <= ST_TOK_END;
              end
            end
          end
          ST_TOK_END: begin
            if (!rx.rx_active) begin
              if (crc_ok) begin
                token_valid <= 1'b1;
                token_pid   <= pid_q;
                token_addr  <= tok_b1[6:0];
                token_endp  <= {tok_endp_hi, tok_b1[7]};
              end else begin
                crc_error <= 1'b1;
              end
              state <= ST_IDLE;
            end else if (rx.rx_valid) begin
              pkt_error <= 1'b1;
              state     <= ST_DISCARD;
            end
          end
          ST_HSK: begin
            if (!rx.rx_active) begin
              hsk_valid <= 1'b1;
              hsk_pid   <= pid_q;
              state     <= ST_IDLE;
            end else if (rx.rx_valid) begin
              pkt_error <= 1'b1;
              state     <= ST_DISCARD;
            end
          end
          ST_DATA: begin
            if (!rx.rx_active) begin
              data_end <= 1'b1;
              state    <= ST_IDLE;
            end else if (rx.rx_valid) begin
              data_valid <= 1'b1;
              data_byte  <= rx.rx_data;
            end
          end
          ST_DISCARD:   if (!rx.rx_active) state <= ST_IDLE;
          default:      state <= ST_SYNC_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_packet_decoder.sv
// tb/tb_usb_packet_decoder.sv - scoreboard bench: directed packets push expected events,
// a negedge monitor pops and compares every output pulse
module tb_usb_packet_decoder;

  localparam int K_TOK    = 1;
  localparam int K_HSK    = 2;
  localparam int K_DSTART = 3;
  localparam int K_DVAL   = 4;
  localparam int K_DEND   = 5;
  localparam int K_PIDERR = 6;
  localparam int K_CRCERR = 7;
  localparam int K_PKTERR = 8;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       token_valid, hsk_valid, data_start, data_valid, data_end;
  logic       pid_error, crc_error, pkt_error;
  logic [3:0] token_pid, token_endp, hsk_pid, data_pid;
  logic [6:0] token_addr;
  logic [7:0] data_byte;

  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  ev_t exp_q[$];

  usb_packet_decoder_if rx();

  usb_packet_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .token_valid (token_valid),
    .token_pid   (token_pid),
    .token_addr  (token_addr),
    .token_endp  (token_endp),
    .hsk_valid   (hsk_valid),
    .hsk_pid     (hsk_pid),
    .data_start  (data_start),
    .data_pid    (data_pid),
    .data_valid  (data_valid),
    .data_byte   (data_byte),
    .data_end    (data_end),
    .pid_error   (pid_error),
    .crc_error   (crc_error),
    .pkt_error   (pkt_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The event is due in the cycle after the current drive cycle
  task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc + 1;
    e.a    = a;
    e.b    = b;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  task automatic seen(input int kind, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d a=%h b=%h c=%h, required none",
               kind, cyc, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.cyc == cyc && e.a == a && e.b == b && e.c == c)
        n_pass++;
      else
        $display("FAIL event: got kind=%0d cyc=%0d a=%h b=%h c=%h, required kind=%0d cyc=%0d a=%h b=%h c=%h",
                 kind, cyc, a, b, c, e.kind, e.cyc, e.a, e.b, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (token_valid) seen(K_TOK, {4'h0, token_pid}, {1'b0, token_addr}, {4'h0, token_endp});
    if (hsk_valid)   seen(K_HSK, {4'h0, hsk_pid}, 8'h00, 8'h00);
    if (data_start)  seen(K_DSTART, {4'h0, data_pid}, 8'h00, 8'h00);
    if (data_valid)  seen(K_DVAL, data_byte, {4'h0, data_pid}, 8'h00);
    if (data_end)    seen(K_DEND, 8'h00, 8'h00, 8'h00);
    if (pid_error)   seen(K_PIDERR, 8'h00, 8'h00, 8'h00);
    if (crc_error)   seen(K_CRCERR, {4'h0, token_pid}, {1'b0, token_addr}, {4'h0, token_endp});
    if (pkt_error)   seen(K_PKTERR, 8'h00, 8'h00, 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic drive(input logic a, input logic v, input logic [7:0] d, input logic e);
    rx.rx_active = a;
    rx.rx_valid  = v;
    rx.rx_data   = d;
    rx.rx_error  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic sop();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic put(input logic [7:0] d);
    drive(1'b1, 1'b1, d, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] payload [4];
    payload[0] = 8'h80;
    payload[1] = 8'h06;
    payload[2] = 8'hAA;
    payload[3] = 8'hBB;

    rx.rx_active = 1'b0;
    rx.rx_valid  = 1'b0;
    rx.rx_data   = 8'h00;
    rx.rx_error  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_pulses", {24'h0, token_valid, hsk_valid, data_start, data_valid,
                         data_end, pid_error, crc_error, pkt_error}, 32'h0);
    chk("reset_token_pid", {28'h0, token_pid}, 32'h0);
    chk("reset_hsk_pid", {28'h0, hsk_pid}, 32'h0);
    chk("reset_data_pid", {28'h0, data_pid}, 32'h0);
    chk("reset_token_addr", {25'h0, token_addr}, 32'h0);
    chk("reset_token_endp", {28'h0, token_endp}, 32'h0);
    chk("reset_data_byte", {24'h0, data_byte}, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(3);

    // IN, addr 0x3A, endp 0xA, CRC5 0x07
    sop(); put(8'h69); put(8'h3A); put(8'h3D);
    expect_ev(K_TOK, 8'h09, 8'h3A, 8'h0A); idle(3);

    // SETUP with corrupted CRC: token fields must still show the IN token
    sop(); put(8'h2D); put(8'h00); put(8'h11);
    expect_ev(K_CRCERR, 8'h09, 8'h3A, 8'h0A); idle(3);

    // SETUP addr 0 endp 0
    sop(); put(8'h2D); put(8'h00); put(8'h10);
    expect_ev(K_TOK, 8'h0D, 8'h00, 8'h00); idle(3);

    // ACK and STALL handshakes
    sop(); put(8'hD2);
    expect_ev(K_HSK, 8'h02, 8'h00, 8'h00); idle(3);
    sop(); put(8'h1E);
    expect_ev(K_HSK, 8'h0E, 8'h00, 8'h00); idle(3);

    // ACK followed by a stray byte
    sop(); put(8'hD2);
    expect_ev(K_PKTERR, 8'h00, 8'h00, 8'h00); put(8'h00); idle(3);

    // DATA0 with two payload bytes plus two CRC16 bytes
    sop();
    expect_ev(K_DSTART, 8'h03, 8'h00, 8'h00); put(8'hC3);
    for (int i = 0; i < 4; i++) begin
      expect_ev(K_DVAL, payload[i], 8'h03, 8'h00);
      put(payload[i]);
    end
    expect_ev(K_DEND, 8'h00, 8'h00, 8'h00); idle(3);

    // Token cut short after two bytes
    sop(); put(8'h69); put(8'h3A);
    expect_ev(K_PKTERR, 8'h00, 8'h00, 8'h00); idle(3);

    // Bad PID check nibble, rest of packet dropped
    sop();
    expect_ev(K_PIDERR, 8'h00, 8'h00, 8'h00); put(8'h6A); put(8'h00); put(8'h10); idle(3);

    // PING is a valid PID but an unsupported class
    sop();
    expect_ev(K_PIDERR, 8'h00, 8'h00, 8'h00); put(8'hB4); put(8'h00); idle(3);

    // DATA1 aborted by a line error: no data_end afterwards
    sop();
    expect_ev(K_DSTART, 8'h0B, 8'h00, 8'h00); put(8'h4B);
    expect_ev(K_DVAL, 8'h11, 8'h0B, 8'h00); put(8'h11);
    expect_ev(K_PKTERR, 8'h00, 8'h00, 8'h00); drive(1'b1, 1'b0, 8'h00, 1'b1);
    put(8'h22); idle(3);

    // Byte strobed together with rx_active falling is ignored
    sop();
    expect_ev(K_DSTART, 8'h03, 8'h00, 8'h00); put(8'hC3);
    expect_ev(K_DVAL, 8'h55, 8'h03, 8'h00); put(8'h55);
    expect_ev(K_DEND, 8'h00, 8'h00, 8'h00); drive(1'b0, 1'b1, 8'h77, 1'b0); idle(2);

    // Reset in the middle of MDATA with rx_active held: rest of packet is silent
    sop();
    expect_ev(K_DSTART, 8'h0F, 8'h00, 8'h00); put(8'h0F);
    expect_ev(K_DVAL, 8'h01, 8'h0F, 8'h00); put(8'h01);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    put(8'h02); put(8'h03); idle(3);

    // OUT addr 0 endp 0 decodes normally after the dropped packet
    sop(); put(8'hE1); put(8'h00); put(8'h10);
    expect_ev(K_TOK, 8'h01, 8'h00, 8'h00); idle(4);

    chk("events_outstanding", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usb_packet_decoder.md
Name: usb_packet_decoder

Overview:
- Receive-side packet decoder in the USB SIE, directly downstream of the bit-level receiver (NRZI decode, bit unstuff, byte assembly).
- Consumes the byte stream of one packet and classifies it by PID.
- Token packets: validates the PID check field and CRC5, then presents PID, address and endpoint.
- Handshake PIDs are reported; data packets are forwarded byte-by-byte with their PID. CRC16 checking is downstream.

Parameters:
- none; PID encodings and token field layout come from the shared types package.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_active  input  1  high from byte after SYNC until EOP; falling edge = end of packet
- rx_valid  input  1  rx_data strobe, one cycle per byte; ignored while rx_active low
- rx_data  input  8  received byte, LSB first on the wire
- rx_error  input  1  bit-stuff/line error pulse from upstream
- token_valid  output  1  one-cycle pulse: good token (OUT/IN/SOF/SETUP) received
- token_pid  output  4  pid_t of last token
- token_addr  output  7  address (SOF: frame[6:0])
- token_endp  output  4  endpoint (SOF: frame[10:7])
- hsk_valid  output  1  one-cycle pulse: good handshake (ACK/NAK/STALL/NYET)
- hsk_pid  output  4  pid_t of last handshake
- data_start  output  1  pulse: DATA0/1/2/MDATA PID accepted
- data_pid  output  4  PID of current data packet
- data_valid  output  1  payload byte strobe (includes the 2 CRC16 bytes)
- data_byte  output  8  payload byte
- data_end  output  1  pulse: data packet ended cleanly
- pid_error  output  1  pulse: rx_data[7:4] != ~rx_data[3:0], or PID class unsupported (PRE/ERR, SPLIT, PING, RESERVED)
- crc_error  output  1  pulse: token CRC5 residual mismatch
- pkt_error  output  1  pulse: wrong length, rx_error, or data packet aborted

Behaviour:
- Reset values: all pulses 0; token_pid/hsk_pid/data_pid = RESERVED; token_addr, token_endp, data_byte = 0.
- PID byte layout: {pidx[3:0], pid[3:0]}.
- Token byte 1: {endp[0], addr[6:0]}. Token byte 2: {crc5[4:0], endp[3:1]}.
- States:
  - SYNC_WAIT: entered on reset; wait for rx_active low, so a packet in progress at reset release is dropped silently; then go to IDLE.
  - IDLE: on rx_active high, go to PID.
  - PID: first rx_valid byte. Check fails or unsupported class → pid_error, DISCARD. Token → TOK1. Handshake → HSK. Data → data_start, latch data_pid, DATA.
  - TOK1 → TOK2 on byte.
  - TOK2 → TOK_END on byte.
  - TOK_END: any further byte → pkt_error, DISCARD. rx_active low → evaluate.
  - HSK: any byte → pkt_error, DISCARD. rx_active low → hsk_valid.
  - DATA: forward each byte with 1-cycle latency (data_valid/data_byte registered). rx_active low → data_end.
  - DISCARD: wait for rx_active low → IDLE. No further pulses.
- rx_active falling in TOK1/TOK2/PID (too short) → pkt_error, IDLE.
- rx_error in any packet state → pkt_error (once), DISCARD. From DATA this also replaces data_end.
- CRC5:
  - Polynomial x^5+x^2+1, register preset 5'b11111, shifted LSB-first over all 16 bits of bytes 1–2.
  - Good residual = 5'b01100.
  - Mismatch → crc_error instead of token_valid.
- Token outputs update only on a good token. token_valid is asserted in the cycle after rx_active is sampled low.
- Latency:
  - token_valid / hsk_valid / data_end: 1 cycle after rx_active sampled low.
  - data_start: 1 cycle after PID byte.
- At most one of token_valid/hsk_valid/data_end/pid_error/crc_error/pkt_error per packet.
- rx_valid coincident with rx_active falling: byte ignored, packet end processed.

Decomposition:
- Add to the types package:
  - rx state enum
  - CRC5 residual constant 5'b01100
  - PID-class helper functions (is_token, is_data, is_handshake), keyed on pid[1:0].
- One sub-module: usb_crc5 (serial-equivalent byte-wide update: init, 8-bit step, residual compare).

Test Plan:
- Bytes 0x2D,0x00,0x10 then rx_active low → token_valid, token_pid=SETUP, addr=0, endp=0; no errors.
- Bytes 0x2D,0x00,0x11 → crc_error only, token_valid stays 0, token_addr unchanged.
- Byte 0xD2 alone → hsk_valid, hsk_pid=ACK. Bytes 0xD2,0x00 → pkt_error only.
- Bytes 0xC3,0x80,0x06,0xAA,0xBB → data_start, data_pid=DATA0; four data_valid pulses with 0x80,0x06,0xAA,0xBB in order; data_end.
- Byte 0x69 with rx_active dropping after 2 bytes → pkt_error. Byte 0x6A (bad check) → pid_error, remaining bytes dropped.
- Reset asserted mid-DATA with rx_active held high, released, bytes continue → no outputs until rx_active low. Next packet 0xE1,0x00,0x10 decodes as OUT.
